// File: rtl/async_queue_sink_n.sv
// Sink half of a clock-crossing queue: synchronises the source's Gray write index and
// alive flag, and presents the head entry of the source storage array as a registered stream.
module async_queue_sink_n #(
   parameter int unsigned WIDTH = 55,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SYNC  = 3,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [DEPTH*WIDTH-1:0] async_mem,
   input  logic [AW:0]            async_widx,
   input  logic                   async_src_valid,
   output logic [AW:0]            async_ridx,
   output logic                   async_snk_valid,
   output logic                   deq_valid,
   input  logic                   deq_ready,
   output logic [WIDTH-1:0]       deq_bits,
   output logic [AW:0]            count
);

   localparam int unsigned IW = AW + 1;

   logic [SYNC-1:0]         src_sync;
   logic [SYNC-1:0][IW-1:0] widx_sync;
   logic                    src_ok;
   logic [IW-1:0]           widx_s;

   logic [IW-1:0]           ridx_bin;
   logic                    valid_reg;

   logic                    fire;
   logic [IW-1:0]           ridx_next;
   logic [IW-1:0]           ridx_gray_next;
   logic                    empty_next;
   logic                    load_head;
   logic [IW-1:0]           count_next;

   logic [WIDTH-1:0]        mem_entry [DEPTH];

   function automatic logic [IW-1:0] gray2bin(input logic [IW-1:0] g);
      logic [IW-1:0] b;
      b = '0;
      for (int i = 0; i < int'(IW); i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   // Unflatten the source storage so entries can be selected by index.
   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_unpack
      assign mem_entry[i] = async_mem[i*WIDTH +: WIDTH];
   end

   // Synchronisers; each Gray bit has its own chain since only one bit moves per write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         src_sync  <= '0;
         widx_sync <= '0;
      end else begin
         src_sync  <= {src_sync[SYNC-2:0], async_src_valid};
         widx_sync <= {widx_sync[SYNC-2:0], async_widx};
      end
   end

   assign src_ok = src_sync[SYNC-1];
   assign widx_s = widx_sync[SYNC-1];

   assign deq_valid = valid_reg & src_ok;
   assign fire      = deq_valid & deq_ready;

   // Next read index, emptiness and occupancy; a dead source collapses everything to zero.
   always_comb begin
      ridx_next      = '0;
      ridx_gray_next = '0;
      empty_next     = 1'b1;
      load_head      = 1'b0;
      count_next     = '0;
      if (src_ok) begin
         ridx_next  = ridx_bin + IW'(fire);
         count_next = gray2bin(widx_s) - ridx_next;
      end
      ridx_gray_next = ridx_next ^ (ridx_next >> 1);
      empty_next     = (ridx_gray_next == widx_s);
      load_head      = src_ok & ~empty_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         async_snk_valid <= 1'b0;
         ridx_bin        <= '0;
         async_ridx      <= '0;
         valid_reg       <= 1'b0;
         count           <= '0;
      end else begin
         async_snk_valid <= 1'b1;
         ridx_bin        <= ridx_next;
         async_ridx      <= ridx_gray_next;
         valid_reg       <= load_head;
         count           <= count_next;
      end
   end

   // Head register; holds across stalls and source loss so deq_bits never glitches.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         deq_bits <= '0;
      end else if (load_head) begin
         deq_bits <= mem_entry[ridx_next[AW-1:0]];
      end
   end

endmodule

// File: tb/tb_async_queue_sink_n.sv
// Directed bench for async_queue_sink_n: reset, single entry, full/drain table,
// burst with index wrap, backpressure, source reset and sink reset.
module tb_async_queue_sink_n;

   localparam int unsigned WIDTH = 55;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned SYNC  = 3;
   localparam int unsigned AW    = 3;

   logic                   clock;
   logic                   reset_n;
   logic [DEPTH*WIDTH-1:0] async_mem;
   logic [AW:0]            async_widx;
   logic                   async_src_valid;
   logic [AW:0]            async_ridx;
   logic                   async_snk_valid;
   logic                   deq_valid;
   logic                   deq_ready;
   logic [WIDTH-1:0]       deq_bits;
   logic [AW:0]            count;

   async_queue_sink_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .async_mem       (async_mem),
      .async_widx      (async_widx),
      .async_src_valid (async_src_valid),
      .async_ridx      (async_ridx),
      .async_snk_valid (async_snk_valid),
      .deq_valid       (deq_valid),
      .deq_ready       (deq_ready),
      .deq_bits        (deq_bits),
      .count           (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic             ready;
      logic             exp_valid;
      logic [WIDTH-1:0] exp_bits;
      logic [3:0]       exp_count;
      logic [3:0]       exp_ridx;
   } drain_vec_t;

   localparam logic [WIDTH-1:0] DBASE = 55'h7A000000000000;
   localparam logic [WIDTH-1:0] T6BASE = 55'h0C0FFEE0000000;

   drain_vec_t tbl [12];
   int n_pass;
   int n_total;
   int wr_bin;
   logic saw_wrap;

   function automatic logic [3:0] gray4(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Source model: write the next entry into storage and advance the Gray write index.
   task automatic push(input logic [WIDTH-1:0] val);
      int idx;
      idx = wr_bin % int'(DEPTH);
      async_mem[idx*WIDTH +: WIDTH] = val;
      wr_bin = (wr_bin + 1) % 16;
      async_widx = gray4(wr_bin);
   endtask

   task automatic run_stream(input int n, input logic [63:0] base, input bit toggle,
                             input int start_ridx, output logic wrapped);
      int   wr_done;
      int   rd_done;
      int   cyc;
      bit   primed;
      logic [3:0] prev_r;
      wr_done = 0;
      rd_done = 0;
      cyc     = 0;
      primed  = 1'b0;
      wrapped = 1'b0;
      prev_r  = async_ridx;
      while (rd_done < n && cyc < 200) begin
         if (deq_valid) begin
            check($sformatf("stream_bits%0d", rd_done), 64'(deq_bits), base + 64'(rd_done));
            primed = 1'b1;
         end else if (primed && !toggle) begin
            check("stream_gap", 64'(deq_valid), 64'd1);
         end
         deq_ready = toggle ? (((cyc / 2) % 2) == 1) : 1'b1;
         if (deq_valid && deq_ready) rd_done++;
         if (wr_done < n && (wr_done - rd_done) < int'(DEPTH)) begin
            push(WIDTH'(base + 64'(wr_done)));
            wr_done++;
         end
         tick();
         cyc++;
         if (prev_r == 4'b1000 && async_ridx == 4'b0000) wrapped = 1'b1;
         prev_r = async_ridx;
      end
      deq_ready = 1'b0;
      check("stream_done", 64'(rd_done), 64'(n));
      check("stream_ridx", 64'(async_ridx), 64'(gray4(start_ridx + n)));
      check("stream_count", 64'(count), 64'd0);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      wr_bin  = 0;

      // Drain table: queue full at binary read index 1, entries DBASE+1..DBASE+8.
      tbl[0]  = '{1'b0, 1'b1, DBASE + 55'd1, 4'd8, 4'd1};
      tbl[1]  = '{1'b0, 1'b1, DBASE + 55'd1, 4'd8, 4'd1};
      tbl[2]  = '{1'b1, 1'b1, DBASE + 55'd2, 4'd7, 4'd3};
      tbl[3]  = '{1'b1, 1'b1, DBASE + 55'd3, 4'd6, 4'd2};
      tbl[4]  = '{1'b0, 1'b1, DBASE + 55'd3, 4'd6, 4'd2};
      tbl[5]  = '{1'b1, 1'b1, DBASE + 55'd4, 4'd5, 4'd6};
      tbl[6]  = '{1'b1, 1'b1, DBASE + 55'd5, 4'd4, 4'd7};
      tbl[7]  = '{1'b1, 1'b1, DBASE + 55'd6, 4'd3, 4'd5};
      tbl[8]  = '{1'b1, 1'b1, DBASE + 55'd7, 4'd2, 4'd4};
      tbl[9]  = '{1'b1, 1'b1, DBASE + 55'd8, 4'd1, 4'd12};
      tbl[10] = '{1'b1, 1'b0, DBASE + 55'd8, 4'd0, 4'd13};
      tbl[11] = '{1'b1, 1'b0, DBASE + 55'd8, 4'd0, 4'd13};

      // T1: reset with random inputs
      reset_n = 1'b0;
      for (int b = 0; b < int'(DEPTH*WIDTH); b++) async_mem[b] = 1'($urandom_range(1, 0));
      async_widx      = 4'($urandom_range(15, 0));
      async_src_valid = 1'($urandom_range(1, 0));
      deq_ready       = 1'($urandom_range(1, 0));
      tick();
      tick();
      check("rst_ridx", 64'(async_ridx), 64'd0);
      check("rst_snk_valid", 64'(async_snk_valid), 64'd0);
      check("rst_deq_valid", 64'(deq_valid), 64'd0);
      check("rst_deq_bits", 64'(deq_bits), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      async_mem = '0;
      async_widx = '0;
      async_src_valid = 1'b0;
      deq_ready = 1'b0;
      reset_n = 1'b1;
      #1;
      check("rel_snk_valid_pre", 64'(async_snk_valid), 64'd0);
      tick();
      check("rel_snk_valid", 64'(async_snk_valid), 64'd1);
      check("rel_deq_valid", 64'(deq_valid), 64'd0);
      async_src_valid = 1'b1;
      repeat (4) tick();
      check("up_count", 64'(count), 64'd0);

      // T2: single entry, visible SYNC+1 clocks after the index change
      push(55'h12345);
      repeat (SYNC) tick();
      check("t2_not_yet", 64'(deq_valid), 64'd0);
      tick();
      check("t2_valid", 64'(deq_valid), 64'd1);
      check("t2_bits", 64'(deq_bits), 64'h12345);
      check("t2_count", 64'(count), 64'd1);
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      check("t2_ridx", 64'(async_ridx), 64'd1);
      check("t2_empty", 64'(deq_valid), 64'd0);
      check("t2_count0", 64'(count), 64'd0);

      // T4: fill to full with ready low, then drain per table
      for (int j = 1; j <= 8; j++) begin
         push(DBASE + WIDTH'(j));
         tick();
      end
      repeat (4) tick();
      for (int i = 0; i < 12; i++) begin
         deq_ready = tbl[i].ready;
         tick();
         check($sformatf("drain%0d_valid", i), 64'(deq_valid), 64'(tbl[i].exp_valid));
         check($sformatf("drain%0d_bits", i), 64'(deq_bits), 64'(tbl[i].exp_bits));
         check($sformatf("drain%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
         check($sformatf("drain%0d_ridx", i), 64'(async_ridx), 64'(tbl[i].exp_ridx));
      end
      deq_ready = 1'b0;

      // T3: 20-entry burst, read index wraps past 15
      run_stream(20, 64'd0, 1'b0, 9, saw_wrap);
      check("t3_gray_wrap", 64'(saw_wrap), 64'd1);

      // T5: backpressure, ready toggles every other clock
      run_stream(6, 64'h3000_0000_0000, 1'b1, 13, saw_wrap);

      // T6: source reset with 3 entries pending
      for (int j = 0; j < 3; j++) push(T6BASE + WIDTH'(j));
      repeat (5) tick();
      check("t6_valid", 64'(deq_valid), 64'd1);
      check("t6_count", 64'(count), 64'd3);
      check("t6_bits", 64'(deq_bits), 64'(T6BASE));
      async_src_valid = 1'b0;
      tick();
      tick();
      check("t6_valid_sync2", 64'(deq_valid), 64'd1);
      tick();
      check("t6_valid_drop", 64'(deq_valid), 64'd0);
      check("t6_count_held", 64'(count), 64'd3);
      check("t6_ridx_held", 64'(async_ridx), 64'(gray4(3)));
      tick();
      check("t6_ridx0", 64'(async_ridx), 64'd0);
      check("t6_count0", 64'(count), 64'd0);
      check("t6_bits_hold", 64'(deq_bits), 64'(T6BASE));
      wr_bin = 0;
      async_widx = '0;
      repeat (3) tick();
      async_src_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("t6_stay_low%0d", k), 64'(deq_valid), 64'd0);
      end
      check("t6_restart_count", 64'(count), 64'd0);
      push(55'h12345678);
      repeat (SYNC + 1) tick();
      check("t6_restart_valid", 64'(deq_valid), 64'd1);
      check("t6_restart_bits", 64'(deq_bits), 64'h12345678);
      check("t6_restart_count1", 64'(count), 64'd1);

      // Sink reset mid-operation clears everything asynchronously
      #2;
      reset_n = 1'b0;
      #1;
      check("srst_ridx", 64'(async_ridx), 64'd0);
      check("srst_snk_valid", 64'(async_snk_valid), 64'd0);
      check("srst_deq_valid", 64'(deq_valid), 64'd0);
      check("srst_bits", 64'(deq_bits), 64'd0);
      check("srst_count", 64'(count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
